// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads four bytes from a byte-wide memory, assembles a
// big-endian word and offers it to decode over a valid/ready handshake.
module instr_fetch_unit #(
   parameter int MEM_BYTES = 128,
   parameter int ADDR_W    = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              busy,
   output logic              halted,
   output logic              halt_cause
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_VALID = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - 4);
   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [2:0]        cnt;
   logic [31:0]       asm_q;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] instr_pc_q;
   logic [ADDR_W-1:0] addr_q;
   logic              cause_q;

   logic              issue;
   logic [ADDR_W-1:0] issue_addr;
   logic [31:0]       word_next;

   // Issue cycles are cnt 0..3; cnt 1..4 are the data cycles for bytes 0..3.
   assign issue      = (state == S_FETCH) && !cnt[2];
   assign issue_addr = pc + {{(ADDR_W-2){1'b0}}, cnt[1:0]};

   // NOTE: every variable in always_comb gets a default first so no latch is inferred.
   always_comb begin
      word_next = asm_q;
      case (cnt)
         3'd1:    word_next[31:24] = mem_rdata;
         3'd2:    word_next[23:16] = mem_rdata;
         3'd3:    word_next[15:8]  = mem_rdata;
         3'd4:    word_next[7:0]   = mem_rdata;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= '0;
         cnt        <= '0;
         asm_q      <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         addr_q     <= '0;
         cause_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_FETCH;
                  cnt   <= '0;
               end
            end
            S_FETCH: begin
               if (issue) addr_q <= issue_addr;
               if (cnt != 3'd0) asm_q <= word_next;
               if (cnt == 3'd4) begin
                  if (word_next == 32'd0) begin
                     state   <= S_HALT;
                     cause_q <= 1'b0;
                  end else begin
                     state      <= S_VALID;
                     instr_q    <= word_next;
                     instr_pc_q <= pc;
                  end
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            S_VALID: begin
               if (instr_ready) begin
                  if (pc == LAST_PC) begin
                     state   <= S_HALT;
                     cause_q <= 1'b1;
                  end else begin
                     state <= S_FETCH;
                     pc    <= pc + PC_STEP;
                     cnt   <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // The address register keeps the last issued address visible while idle.
   assign mem_rd      = issue;
   assign mem_addr    = issue ? issue_addr : addr_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = (state == S_VALID);
   assign busy        = (state == S_FETCH) || (state == S_VALID);
   assign halted      = (state == S_HALT);
   assign halt_cause  = cause_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table of program images with a
// transfer scoreboard, plus hand sequences for latency and mid-fetch reset.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        mem_rd;
   logic [6:0]  mem_addr;
   logic [7:0]  mem_rdata = 8'd0;
   logic [31:0] instr;
   logic [6:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        busy;
   logic        halted;
   logic        halt_cause;

   instr_fetch_unit #(.MEM_BYTES(128), .ADDR_W(7)) dut (
      .clk(clk), .rst(rst), .start(start),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .busy(busy), .halted(halted),
      .halt_cause(halt_cause)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [128];
   always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] word;
      logic [6:0]  pc;
   } xfer_t;
   xfer_t sb[$];

   typedef struct {
      logic [31:0] first_word;
      int          n_words;
      int          mode;        // 0 ready=1, 1 stall 10 cycles, 2 toggle
      bit          poke;        // pulse start while busy
      logic        exp_cause;
      int          exp_xfers;
      int          exp_max_addr;
   } vec_t;
   vec_t vecs[7];

   int  mode = 0;
   bit  mon_en = 1'b0;
   int  exp_addr = 0;
   int  max_addr = -1;
   int  xfers = 0;
   int  stalls = 0;

   // Ready driver: changes just after the active edge.
   initial begin
      int vcnt;
      vcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (instr_valid) vcnt++; else vcnt = 0;
         case (mode)
            0:       instr_ready = 1'b1;
            1:       instr_ready = (vcnt > 10);
            default: instr_ready = ~instr_ready;
         endcase
      end
   end

   // Monitor on the falling edge: address order, transfers, held outputs.
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_rd) begin
            check("mem_addr_seq", 32'(mem_addr), 32'(exp_addr));
            exp_addr++;
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
         end
         if (instr_valid && instr_ready) begin
            xfers++;
            if (sb.size() == 0) begin
               check("unexpected_xfer", 32'd1, 32'd0);
            end else begin
               xfer_t e;
               e = sb.pop_front();
               check("xfer_instr", instr, e.word);
               check("xfer_pc", 32'(instr_pc), 32'(e.pc));
            end
         end else if (instr_valid && sb.size() != 0) begin
            stalls++;
            check("stall_instr", instr, sb[0].word);
            check("stall_pc", 32'(instr_pc), 32'(sb[0].pc));
            check("stall_mem_rd", 32'(mem_rd), 32'd0);
         end
      end
   end

   task automatic load_image(input logic [31:0] first, input int n);
      for (int i = 0; i < 32; i++) begin
         logic [31:0] w;
         w = (i < n) ? first + 32'(i) : 32'd0;
         mem[4*i]   = w[31:24];
         mem[4*i+1] = w[23:16];
         mem[4*i+2] = w[15:8];
         mem[4*i+3] = w[7:0];
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1; start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_instr"}, instr, 32'd0);
      check({tag, "_instr_pc"}, 32'(instr_pc), 32'd0);
      check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_halted"}, 32'(halted), 32'd0);
      check({tag, "_halt_cause"}, 32'(halt_cause), 32'd0);
   endtask

   task automatic wait_valid(input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (instr_valid) begin seen = 1'b1; break; end
      end
      check({tag, "_valid_timeout"}, 32'(seen), 32'd1);
   endtask

   initial begin
      vecs[0] = '{32'h0050_8133, 1,  0, 1'b0, 1'b0, 1,  7};
      vecs[1] = '{32'h0050_8133, 1,  1, 1'b0, 1'b0, 1,  7};
      vecs[2] = '{32'h0000_0001, 32, 0, 1'b0, 1'b1, 32, 127};
      vecs[3] = '{32'h1234_5678, 3,  2, 1'b1, 1'b0, 3,  15};
      vecs[4] = '{32'h0000_0000, 0,  0, 1'b0, 1'b0, 0,  3};
      vecs[5] = '{32'hffff_fffe, 2,  1, 1'b1, 1'b0, 2,  11};
      vecs[6] = '{32'h0000_0001, 32, 2, 1'b1, 1'b1, 32, 127};

      for (int v = 0; v < 7; v++) begin
         bit done;
         logic [31:0] last_word;
         mode = vecs[v].mode;
         do_reset();
         check_reset_outputs("reset");
         load_image(vecs[v].first_word, vecs[v].n_words);
         sb.delete();
         for (int i = 0; i < vecs[v].n_words; i++)
            sb.push_back('{vecs[v].first_word + 32'(i), 7'(4*i)});
         exp_addr = 0; max_addr = -1; xfers = 0; stalls = 0;
         mon_en = 1'b1;
         @(posedge clk); #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         done = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start = vecs[v].poke && (c % 7 == 3);
            if (halted) begin done = 1'b1; break; end
         end
         start = 1'b0;
         check("halt_timeout", 32'(done), 32'd1);
         for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 start = k[0];
            check("halt_sticky", 32'(halted), 32'd1);
            check("halt_busy", 32'(busy), 32'd0);
            check("halt_mem_rd", 32'(mem_rd), 32'd0);
         end
         start = 1'b0;
         @(negedge clk);
         mon_en = 1'b0;
         last_word = (vecs[v].n_words > 0) ? vecs[v].first_word + 32'(vecs[v].n_words - 1) : 32'd0;
         check("halt_cause", 32'(halt_cause), 32'(vecs[v].exp_cause));
         check("xfer_count", 32'(xfers), 32'(vecs[v].exp_xfers));
         check("sb_empty", 32'(sb.size()), 32'd0);
         check("max_addr", 32'(max_addr), 32'(vecs[v].exp_max_addr));
         check("instr_held", instr, last_word);
         if (vecs[v].mode == 1)
            check("stall_cycles", 32'(stalls), 32'(vecs[v].exp_xfers * 10));
      end

      // Latency and issue sequence of the first word.
      mode = 0;
      do_reset();
      load_image(32'h0050_8133, 1);
      mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("lat_rd0", 32'(mem_rd), 32'd1);
      check("lat_addr0", 32'(mem_addr), 32'd0);
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk); #1;
         if (e <= 3) begin
            check("lat_rd", 32'(mem_rd), 32'd1);
            check("lat_addr", 32'(mem_addr), 32'(e));
         end else begin
            check("lat_rd_off", 32'(mem_rd), 32'd0);
         end
         check("lat_valid", 32'(instr_valid), (e == 5) ? 32'd1 : 32'd0);
      end
      check("lat_instr", instr, 32'h0050_8133);
      check("lat_pc", 32'(instr_pc), 32'd0);

      // Reset in the 3rd fetch cycle of the second word.
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #1;
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_addr", 32'(mem_addr), 32'd6);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check_reset_outputs("midrst");
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("refetch_addr0", 32'(mem_addr), 32'd0);
      wait_valid("refetch");
      check("refetch_instr", instr, 32'h0050_8133);
      check("refetch_pc", 32'(instr_pc), 32'd0);
      wait_valid("second");
      check("second_instr", instr, 32'h1122_3344);
      check("second_pc", 32'(instr_pc), 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
